// File: rtl/uart_asm_pkg.sv
// Shared types and constants for the UART byte-to-sample assembler.
package uart_asm_pkg;

  typedef enum logic [1:0] {
    HUNT    = 2'd0,
    PAYLOAD = 2'd1,
    CHECK   = 2'd2,
    EMIT    = 2'd3
  } asm_state_e;

  localparam logic [7:0] DEFAULT_HEADER = 8'hA5;

  function automatic int bytes_for_width(input int width);
    return (width + 32'sd7) / 32'sd8;
  endfunction

endpackage

// File: rtl/uart_sample_assembler.sv
// Packs UART bytes (header + LSB-first payload) into signed samples for the CIC.
// Define UART_ASM_CHECKSUM_EN to require a trailing XOR checksum byte per frame.
module uart_sample_assembler
  import uart_asm_pkg::*;
#(
  parameter int         SAMPLE_W    = 16,
  parameter logic [7:0] HEADER      = DEFAULT_HEADER,
  parameter int         TIMEOUT_CYC = 50000
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [7:0]          rx_data,
  input  logic                rx_data_valid,
  output logic                rx_data_ready,
  output logic [SAMPLE_W-1:0] sample_data,
  output logic                sample_valid,
  input  logic                sample_ready,
  output logic                frame_err,
  output logic [7:0]          err_cnt
);

  localparam int BYTES = bytes_for_width(SAMPLE_W);
  localparam int ASM_W = 8 * BYTES;
  localparam int IDX_W = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam int TO_W  = $clog2(TIMEOUT_CYC);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BYTES - 1);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYC - 1);

  asm_state_e          state_r, state_nxt_s;
  logic [ASM_W-1:0]    asm_r, asm_nxt_s;
  logic [IDX_W-1:0]    idx_r, idx_nxt_s;
  logic [TO_W-1:0]     to_cnt_r, to_cnt_nxt_s;
  logic [SAMPLE_W-1:0] sample_data_r;
  logic                sample_valid_r;
  logic                frame_err_r;
  logic [7:0]          err_cnt_r;
  logic                accept_s;
  logic                err_s;
`ifdef UART_ASM_CHECKSUM_EN
  logic [7:0]          ck_r, ck_nxt_s;
`endif

  assign rx_data_ready = (state_r != EMIT);
  assign accept_s      = rx_data_valid && rx_data_ready;
  assign sample_data   = sample_data_r;
  assign sample_valid  = sample_valid_r;
  assign frame_err     = frame_err_r;
  assign err_cnt       = err_cnt_r;

  // Next-state, byte assembly and inter-byte timeout decisions.
  always_comb begin
    state_nxt_s  = state_r;
    asm_nxt_s    = asm_r;
    idx_nxt_s    = idx_r;
    to_cnt_nxt_s = to_cnt_r;
    err_s        = 1'b0;
`ifdef UART_ASM_CHECKSUM_EN
    ck_nxt_s     = ck_r;
`endif
    case (state_r)
      HUNT: begin
        to_cnt_nxt_s = '0;
        if (accept_s && (rx_data == HEADER)) begin
          state_nxt_s = PAYLOAD;
          idx_nxt_s   = '0;
          asm_nxt_s   = '0;
`ifdef UART_ASM_CHECKSUM_EN
          ck_nxt_s    = 8'h00;
`endif
        end else begin
          state_nxt_s = HUNT;
        end
      end
      PAYLOAD, CHECK: begin
        if (accept_s) begin
          // An accepted byte always wins over a coincident timeout.
          to_cnt_nxt_s = '0;
          if (state_r == PAYLOAD) begin
            asm_nxt_s[{idx_r, 3'b000} +: 8] = rx_data;
`ifdef UART_ASM_CHECKSUM_EN
            ck_nxt_s = ck_r ^ rx_data;
`endif
            if (idx_r == LAST_IDX) begin
              idx_nxt_s = '0;
`ifdef UART_ASM_CHECKSUM_EN
              state_nxt_s = CHECK;
`else
              state_nxt_s = EMIT;
`endif
            end else begin
              idx_nxt_s = idx_r + IDX_W'(1);
            end
          end else begin
`ifdef UART_ASM_CHECKSUM_EN
            if (rx_data == ck_r) begin
              state_nxt_s = EMIT;
            end else begin
              state_nxt_s = HUNT;
              err_s       = 1'b1;
            end
`else
            state_nxt_s = HUNT;
`endif
          end
        end else if (to_cnt_r == TO_LAST) begin
          state_nxt_s  = HUNT;
          err_s        = 1'b1;
          to_cnt_nxt_s = '0;
          idx_nxt_s    = '0;
        end else begin
          to_cnt_nxt_s = to_cnt_r + TO_W'(1);
        end
      end
      EMIT: begin
        to_cnt_nxt_s = '0;
        if (sample_ready) begin
          state_nxt_s = HUNT;
        end else begin
          state_nxt_s = EMIT;
        end
      end
      default: begin
        state_nxt_s  = HUNT;
        idx_nxt_s    = '0;
        to_cnt_nxt_s = '0;
      end
    endcase
  end

  // Frame-tracking state: FSM, assembly register, byte index, timeout counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= HUNT;
      asm_r    <= '0;
      idx_r    <= '0;
      to_cnt_r <= '0;
`ifdef UART_ASM_CHECKSUM_EN
      ck_r     <= 8'h00;
`endif
    end else begin
      state_r  <= state_nxt_s;
      asm_r    <= asm_nxt_s;
      idx_r    <= idx_nxt_s;
      to_cnt_r <= to_cnt_nxt_s;
`ifdef UART_ASM_CHECKSUM_EN
      ck_r     <= ck_nxt_s;
`endif
    end
  end

  // Output registers; sample_data only reloads on entry to EMIT so errors leave it intact.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sample_data_r  <= '0;
      sample_valid_r <= 1'b0;
      frame_err_r    <= 1'b0;
      err_cnt_r      <= 8'd0;
    end else begin
      sample_valid_r <= (state_nxt_s == EMIT);
      frame_err_r    <= err_s;
      if ((state_r != EMIT) && (state_nxt_s == EMIT)) begin
        sample_data_r <= asm_nxt_s[SAMPLE_W-1:0];
      end
      if (err_s && (err_cnt_r != 8'hFF)) begin
        err_cnt_r <= err_cnt_r + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_uart_sample_assembler.sv
// Self-checking bench: 16-bit instance (table, hand sequences, random vs. model)
// plus a 12-bit instance for sign/ignored-bits and mid-frame reset checks.
module tb_uart_sample_assembler;

  localparam int TO = 100;
`ifdef UART_ASM_CHECKSUM_EN
  localparam bit CK_EN = 1'b1;
`else
  localparam bit CK_EN = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic [7:0]  rx_data;
  logic        rx_valid_a, rx_valid_b;
  logic        rx_ready_a, rx_ready_b;
  logic [15:0] sample_data_a;
  logic [11:0] sample_data_b;
  logic        sample_valid_a, sample_valid_b;
  logic        sample_ready_a, sample_ready_b;
  logic        frame_err_a, frame_err_b;
  logic [7:0]  err_cnt_a, err_cnt_b;

  logic        man_ready, rnd_en, rnd_val;
  assign sample_ready_a = rnd_en ? rnd_val : man_ready;

  uart_sample_assembler #(.SAMPLE_W(16), .HEADER(8'hA5), .TIMEOUT_CYC(TO)) dut_a (
    .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_data_valid(rx_valid_a),
    .rx_data_ready(rx_ready_a), .sample_data(sample_data_a), .sample_valid(sample_valid_a),
    .sample_ready(sample_ready_a), .frame_err(frame_err_a), .err_cnt(err_cnt_a));

  uart_sample_assembler #(.SAMPLE_W(12), .HEADER(8'hA5), .TIMEOUT_CYC(TO)) dut_b (
    .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_data_valid(rx_valid_b),
    .rx_data_ready(rx_ready_b), .sample_data(sample_data_b), .sample_valid(sample_valid_b),
    .sample_ready(sample_ready_b), .frame_err(frame_err_b), .err_cnt(err_cnt_b));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int pulses_a = 0;
  int pulses_b = 0;
  logic [15:0] got_a[$];
  logic [11:0] got_b[$];

  always @(posedge clk) begin
    #1 rnd_val = ($urandom_range(0, 3) != 0);
  end

  // Scoreboard capture: handshakes and error pulses seen mid-cycle.
  always @(negedge clk) begin
    if (sample_valid_a && sample_ready_a) got_a.push_back(sample_data_a);
    if (sample_valid_b && sample_ready_b) got_b.push_back(sample_data_b);
    if (frame_err_a) pulses_a++;
    if (frame_err_b) pulses_b++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send(input bit to_b, input logic [7:0] b);
    int n;
    n = 0;
    @(negedge clk);
    rx_data = b;
    if (to_b) rx_valid_b = 1'b1; else rx_valid_a = 1'b1;
    while (!(to_b ? rx_ready_b : rx_ready_a) && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 1000) begin
      n_checks++;
      n_fail++;
      $display("FAIL send_wait: rx_data_ready stuck low for %0d cycles, required high", n);
    end
    @(posedge clk);
    #1;
    rx_valid_a = 1'b0;
    rx_valid_b = 1'b0;
  endtask

  task automatic send_frame(input bit to_b, input logic [7:0] p0, input logic [7:0] p1,
                            input bit corrupt, input int gap_max);
    send(to_b, 8'hA5);
    idle($urandom_range(0, gap_max));
    send(to_b, p0);
    idle($urandom_range(0, gap_max));
    send(to_b, p1);
    if (CK_EN) begin
      idle($urandom_range(0, gap_max));
      send(to_b, (p0 ^ p1) ^ (corrupt ? 8'hFF : 8'h00));
    end
  endtask

  function automatic logic [15:0] last_a();
    return (got_a.size() > 0) ? got_a[got_a.size() - 1] : 16'hDEAD;
  endfunction

  typedef struct {
    logic [7:0]  pre;
    bit          has_pre;
    logic [7:0]  p0;
    logic [7:0]  p1;
    bit          corrupt;
    logic [15:0] exp;
  } vec_t;

  vec_t        vecs[8];
  logic [15:0] exp_q[$];
  int          exp_errs, exp_pulses, base, base_p, n;
  bit          seen, corrupt;
  logic [7:0]  gb, p0, p1;
  logic [15:0] held;

  initial begin
    vecs[0] = '{8'h00, 1'b0, 8'h34, 8'h12, 1'b0, 16'h1234};
    vecs[1] = '{8'h00, 1'b1, 8'hCD, 8'hAB, 1'b0, 16'hABCD};
    vecs[2] = '{8'hFF, 1'b1, 8'hA5, 8'hA5, 1'b0, 16'hA5A5};
    vecs[3] = '{8'h12, 1'b1, 8'h00, 8'h80, 1'b1, 16'h8000};
    vecs[4] = '{8'h00, 1'b0, 8'hFF, 8'hFF, 1'b0, 16'hFFFF};
    vecs[5] = '{8'h5A, 1'b1, 8'h02, 8'h01, 1'b0, 16'h0102};
    vecs[6] = '{8'h00, 1'b0, 8'h78, 8'h56, 1'b1, 16'h5678};
    vecs[7] = '{8'h00, 1'b0, 8'h00, 8'h00, 1'b0, 16'h0000};

    rst_n = 1'b0; rx_data = 8'h00; rx_valid_a = 1'b0; rx_valid_b = 1'b0;
    man_ready = 1'b1; rnd_en = 1'b0; sample_ready_b = 1'b1;
    exp_errs = 0; exp_pulses = 0;
    idle(3);
    check("reset_rx_ready", rx_ready_a, 1);
    check("reset_sample_valid", sample_valid_a, 0);
    check("reset_sample_data", sample_data_a, 0);
    check("reset_frame_err", frame_err_a, 0);
    check("reset_err_cnt", err_cnt_a, 0);
    rst_n = 1'b1;
    idle(2);
    check("idle_rx_ready", rx_ready_a, 1);

    // First-sample latency and single-cycle EMIT under a ready sink.
    send_frame(1'b0, 8'h34, 8'h12, 1'b0, 0);
    check("lat_valid_t1", sample_valid_a, 1);
    check("lat_ready_low", rx_ready_a, 0);
    check("lat_data", sample_data_a, 16'h1234);
    @(posedge clk); #1;
    check("hs_valid_drop", sample_valid_a, 0);
    check("hs_ready_back", rx_ready_a, 1);

    // Leading garbage, then one frame, no error.
    base = got_a.size(); base_p = pulses_a;
    send(1'b0, 8'h00); send(1'b0, 8'hFF); send(1'b0, 8'h12);
    send_frame(1'b0, 8'hCD, 8'hAB, 1'b0, 0);
    idle(3);
    check("garbage_one_sample", got_a.size() - base, 1);
    check("garbage_data", last_a(), 16'hABCD);
    check("garbage_no_err", pulses_a - base_p, 0);

    // Table-driven frames.
    for (int i = 0; i < 8; i++) begin
      base = got_a.size();
      if (vecs[i].has_pre) send(1'b0, vecs[i].pre);
      send_frame(1'b0, vecs[i].p0, vecs[i].p1, vecs[i].corrupt, 2);
      idle(3);
      if (CK_EN && vecs[i].corrupt) begin
        exp_errs++; exp_pulses++;
        check("vec_no_sample", got_a.size() - base, 0);
      end else begin
        check("vec_count", got_a.size() - base, 1);
        check("vec_data", last_a(), vecs[i].exp);
      end
      check("vec_err_cnt", err_cnt_a, exp_errs);
      check("vec_err_pulses", pulses_a, exp_pulses);
    end

    // Back-pressure: 20 cycles held in EMIT.
    @(posedge clk); #1 man_ready = 1'b0;
    send_frame(1'b0, 8'h5A, 8'hC3, 1'b0, 0);
    held = 16'hC35A;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("bp_valid", sample_valid_a, 1);
      check("bp_rx_ready", rx_ready_a, 0);
      check("bp_data_stable", sample_data_a, held);
    end
    @(posedge clk); #1 man_ready = 1'b1;
    send_frame(1'b0, 8'h02, 8'h01, 1'b0, 0);
    idle(3);
    check("bp_prev", (got_a.size() > 1) ? got_a[got_a.size() - 2] : 16'hDEAD, 16'hC35A);
    check("bp_next", last_a(), 16'h0102);

    // Timeout, then recovery.
    base_p = pulses_a;
    send(1'b0, 8'hA5); send(1'b0, 8'h34);
    n = 0; seen = 1'b0;
    while (!seen && n < TO + 20) begin
      @(negedge clk);
      n++;
      if (frame_err_a) seen = 1'b1;
    end
    check("to_fired", seen, 1);
    check("to_latency_window", (n >= TO - 2) && (n <= TO + 3), 1);
    idle(3);
    exp_errs++; exp_pulses++;
    check("to_single_pulse", pulses_a - base_p, 1);
    check("to_err_cnt", err_cnt_a, exp_errs);
    check("to_data_kept", sample_data_a, 16'h0102);
    send_frame(1'b0, 8'h78, 8'h56, 1'b0, 0);
    idle(3);
    check("to_recover", last_a(), 16'h5678);

    // Gaps just under the timeout must not abort the frame.
    base = got_a.size();
    send(1'b0, 8'hA5); idle(TO - 10);
    send(1'b0, 8'h11); idle(TO - 10);
    send(1'b0, 8'h22);
    if (CK_EN) begin idle(TO - 10); send(1'b0, 8'h33); end
    idle(3);
    check("slow_count", got_a.size() - base, 1);
    check("slow_data", last_a(), 16'h2211);
    check("slow_no_err", pulses_a, exp_pulses);

    // Randomized frames against the reference model.
    base = got_a.size();
    exp_q.delete();
    @(posedge clk); #1 rnd_en = 1'b1;
    for (int f = 0; f < 60; f++) begin
      for (int g = 0; g < $urandom_range(0, 2); g++) begin
        gb = 8'($urandom_range(0, 255));
        if (gb == 8'hA5) gb = 8'h5A;
        send(1'b0, gb);
      end
      if ($urandom_range(0, 7) == 0) begin
        send(1'b0, 8'hA5);
        if ($urandom_range(0, 1) == 1) send(1'b0, 8'($urandom_range(0, 255)));
        idle(TO + 5);
        exp_errs++; exp_pulses++;
      end else begin
        p0 = 8'($urandom_range(0, 255));
        p1 = 8'($urandom_range(0, 255));
        corrupt = CK_EN && ($urandom_range(0, 4) == 0);
        send_frame(1'b0, p0, p1, corrupt, 3);
        if (corrupt) begin
          exp_errs++; exp_pulses++;
        end else begin
          exp_q.push_back(16'(int'(p1) * 256 + int'(p0)));
        end
      end
    end
    @(posedge clk); #1 rnd_en = 1'b0;
    idle(10);
    check("rand_count", got_a.size() - base, exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      if (base + i < got_a.size()) check("rand_data", got_a[base + i], exp_q[i]);
    end
    check("rand_err_cnt", err_cnt_a, exp_errs);
    check("rand_err_pulses", pulses_a, exp_pulses);

    // 12-bit instance: upper bits of the last byte ignored, then mid-frame reset.
    send_frame(1'b1, 8'hFF, 8'hFF, 1'b0, 0);
    idle(3);
    check("w12_count", got_b.size(), 1);
    check("w12_minus_one", (got_b.size() > 0) ? got_b[0] : 12'h0, 12'hFFF);
    send(1'b1, 8'hA5); send(1'b1, 8'hFF);
    @(negedge clk); rst_n = 1'b0; #1;
    check("rst_mid_valid", sample_valid_b, 0);
    check("rst_mid_ready", rx_ready_b, 1);
    check("rst_err_cnt_a", err_cnt_a, 0);
    exp_errs = 0;
    idle(3);
    rst_n = 1'b1;
    idle(TO + 10);
    check("rst_no_sample", got_b.size(), 1);
    check("rst_no_err", pulses_b, 0);
    send_frame(1'b1, 8'h01, 8'h00, 1'b0, 0);
    idle(3);
    check("w12_after_rst_count", got_b.size(), 2);
    check("w12_after_rst_data", (got_b.size() > 1) ? got_b[1] : 12'h0, 12'h001);
    check("w12_err_cnt", err_cnt_b, 0);

    // Error counter saturation.
    base_p = pulses_a;
    for (int i = 0; i < 256; i++) begin
      send(1'b0, 8'hA5);
      idle(TO + 5);
      exp_errs++;
    end
    check("sat_err_cnt", err_cnt_a, (exp_errs > 255) ? 255 : exp_errs);
    check("sat_pulses", pulses_a - base_p, 256);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
